// File: rtl/rotate_seq_ctrl_pkg.sv
// rotate_seq_ctrl_pkg
// Shared definitions for the sequential rotate controller: the FSM state
// encoding, the rotate-direction codes and the default word/count widths.
// Ports: none (package).
package rotate_seq_ctrl_pkg;

    localparam int N_DEF = 16;
    localparam int C_DEF = 4;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/rotate_seq_ctrl_if.sv
// rotate_seq_ctrl_if
// Request/result handshake bundle between the ALU issue logic (master) and
// the sequential rotate controller (slave).
// Signals:
//   in_valid/in_ready   request handshake
//   in_data [N-1:0]     word to rotate
//   in_cnt  [C-1:0]     rotate amount
//   in_dir              0 = rotate right, 1 = rotate left
//   out_valid/out_ready result handshake
//   out_data [N-1:0]    rotated word
interface rotate_seq_ctrl_if
    import rotate_seq_ctrl_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int C = C_DEF
);

    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_data;
    logic [C-1:0] in_cnt;
    logic         in_dir;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_data;

    modport master (
        output in_valid, in_data, in_cnt, in_dir, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_cnt, in_dir, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/rotate_seq_ctrl_rot_stage.sv
// rot_stage
// Single shared rotate stage: rotates data_i right by 2^stage_i positions.
// Purely combinational; whether the stage result is used is decided by the
// controller.
// Ports:
//   data_i  [N-1:0]  word to rotate
//   stage_i [SW-1:0] stage index (0 .. C-1)
//   data_o  [N-1:0]  data_i rotated right by 2^stage_i
module rot_stage #(
    parameter int N  = 16,
    parameter int C  = 4,
    parameter int SW = (C > 1) ? $clog2(C) : 1
) (
    input  logic [N-1:0]  data_i,
    input  logic [SW-1:0] stage_i,
    output logic [N-1:0]  data_o
);

    logic [C-1:0] amt;

    // 2^stage always fits in C bits because stage never exceeds C-1.
    always_comb begin
        amt = {{(C-1){1'b0}}, 1'b1} << stage_i;
    end

    // Output bit i takes input bit (i + amt) mod N, which is a right rotate.
    always_comb begin
        data_o = '0;
        for (int i = 0; i < N; i++) begin
            data_o[i] = data_i[(i + int'(amt)) % N];
        end
    end

endmodule

// File: rtl/rotate_seq_ctrl.sv
// rotate_seq_ctrl
// Multi-cycle rotate controller. A request is latched in IDLE, then one
// count bit is applied per cycle (MSB first) through a single shared
// rot_stage, and the result is offered with a valid/ready handshake.
// Left rotates are converted at accept time into the equivalent right
// rotate by (N - cnt) mod N, so the datapath only ever rotates right.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    rotate_seq_ctrl_if.slave (request and result handshakes)
//   busy   high while in RUN or DONE
// Configuration:
//   ROT_SKIP_ZERO_EN  when defined, RUN visits only stages whose count bit
//                     is set, and a zero count goes straight to DONE.
//                     Results are identical; only latency changes.
module rotate_seq_ctrl
    import rotate_seq_ctrl_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int C = C_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    rotate_seq_ctrl_if.slave      bus,
    output logic                  busy
);

    localparam int SW = (C > 1) ? $clog2(C) : 1;

    state_t        state_q, state_d;
    logic [N-1:0]  acc_q,   acc_d;
    logic [C-1:0]  cnt_q,   cnt_d;
    logic [SW-1:0] stage_q, stage_d;
    logic [N-1:0]  out_q,   out_d;

    logic [N-1:0]  stage_data;
    logic [C-1:0]  eff_cnt;

    rot_stage #(
        .N  (N),
        .C  (C),
        .SW (SW)
    ) u_rot_stage (
        .data_i  (acc_q),
        .stage_i (stage_q),
        .data_o  (stage_data)
    );

    // Left by k equals right by (N - k) mod N; with N = 2^C that is just
    // the C-bit two's complement negation of the count.
    always_comb begin
        eff_cnt = (bus.in_dir == DIR_LEFT) ? ({C{1'b0}} - bus.in_cnt) : bus.in_cnt;
    end

`ifdef ROT_SKIP_ZERO_EN
    logic [SW:0] nxt_stage;

    // Returns {found, index} of the highest set bit of bits below index lim.
    function automatic logic [SW:0] highest_set_below(input logic [C-1:0] bits,
                                                      input int           lim);
        logic [SW:0] res;
        res = '0;
        for (int i = 0; i < C; i++) begin
            if (i < lim && bits[i]) begin
                res = {1'b1, SW'(i)};
            end
        end
        return res;
    endfunction
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            stage_q <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            stage_q <= stage_d;
            out_q   <= out_d;
        end
    end

    // out_d is only loaded on the transition into DONE, so the result
    // register holds its last value through DONE and the following IDLE.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        stage_d = stage_q;
        out_d   = out_q;
`ifdef ROT_SKIP_ZERO_EN
        nxt_stage = '0;
`endif

        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    acc_d = bus.in_data;
                    cnt_d = eff_cnt;
`ifdef ROT_SKIP_ZERO_EN
                    nxt_stage = highest_set_below(eff_cnt, C);
                    if (nxt_stage[SW]) begin
                        stage_d = nxt_stage[SW-1:0];
                        state_d = ST_RUN;
                    end else begin
                        stage_d = '0;
                        out_d   = bus.in_data;
                        state_d = ST_DONE;
                    end
`else
                    stage_d = SW'(C - 1);
                    state_d = ST_RUN;
`endif
                end
            end

            ST_RUN: begin
                if (cnt_q[stage_q]) begin
                    acc_d = stage_data;
                end
`ifdef ROT_SKIP_ZERO_EN
                nxt_stage = highest_set_below(cnt_q, int'(stage_q));
                if (nxt_stage[SW]) begin
                    stage_d = nxt_stage[SW-1:0];
                end else begin
                    out_d   = acc_d;
                    state_d = ST_DONE;
                end
`else
                if (stage_q == '0) begin
                    out_d   = acc_d;
                    state_d = ST_DONE;
                end else begin
                    stage_d = stage_q - SW'(1);
                end
`endif
            end

            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // All handshake outputs decode straight from the state register, so an
    // asynchronous reset drops out_valid immediately.
    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.out_data  = out_q;
    assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rotate_seq_ctrl.sv
// tb_rotate_seq_ctrl
// Self-checking bench for rotate_seq_ctrl. Expected words come from a
// bit-permutation model of a rotate; expected latency comes from the count
// of clock edges from the accept edge (inclusive) until out_valid is seen.
// Build with ROT_SKIP_ZERO_EN defined to check the skip-zero timing.
module tb_rotate_seq_ctrl;
    import rotate_seq_ctrl_pkg::*;

    localparam int N = 16;
    localparam int C = 4;
    localparam int MAX_EDGES = 40;

    logic clk = 1'b0;
    logic rst_n;
    logic busy;

    int errors = 0;
    int checks = 0;

    rotate_seq_ctrl_if #(.N(N), .C(C)) bus ();

    rotate_seq_ctrl #(
        .N (N),
        .C (C)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    // Reference rotate: move each bit to its new position directly.
    function automatic logic [N-1:0] modelRot(input logic [N-1:0] d, input int k, input bit left);
        logic [N-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            if (left) r[(i + k) % N]     = d[i];
            else      r[(i - k + N) % N] = d[i];
        end
        return r;
    endfunction

    // Edges from the accept edge (counted as 1) to the edge after which
    // out_valid is observed.
    function automatic int modelLatency(input int k, input bit left);
        int eff;
        int ones;
        eff  = left ? (N - k) % N : k;
        ones = 0;
        for (int i = 0; i < C; i++) if ((eff >> i) & 1) ones++;
`ifdef ROT_SKIP_ZERO_EN
        return (eff == 0) ? 1 : 1 + ones;
`else
        return C + 1;
`endif
    endfunction

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Presents a request while the controller is idle; the next edge accepts
    // it. Inputs are scrambled afterwards since they need not be held.
    task automatic sendRequest(input logic [N-1:0] d, input logic [C-1:0] k, input logic dir);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_cnt   = k;
        bus.in_dir   = dir;
        stepCycle();
        bus.in_valid = 1'b0;
        bus.in_data  = N'($urandom);
        bus.in_cnt   = C'($urandom);
        bus.in_dir   = 1'($urandom);
    endtask

    task automatic waitResult(output int edges);
        edges = 1;
        while (bus.out_valid !== 1'b1 && edges < MAX_EDGES) begin
            stepCycle();
            edges++;
        end
    endtask

    task automatic handshake();
        bus.out_ready = 1'b1;
        stepCycle();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        int edges;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 16'h1234;
        bus.in_cnt    = 4'd4;
        bus.in_dir    = DIR_RIGHT;
        bus.out_ready = 1'b0;
        #3;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready got=%b want=1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got=%b want=0", bus.out_valid); end
        checks++; if (bus.out_data !== 16'h0000) begin errors++; $display("[TB] FAIL reset_out_data got=%h want=0000", bus.out_data); end
        stepCycle();
        stepCycle();
        checks++; if (busy !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_held busy=%b in_ready=%b want 0/1", busy, bus.in_ready); end
        rst_n = 1'b1;
        stepCycle();
        bus.in_valid = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL first_edge_accept busy=%b want=1", busy); end
        waitResult(edges);
        checks++; if (edges != modelLatency(4, 1'b0)) begin errors++; $display("[TB] FAIL latency_1234_r4 got=%0d want=%0d", edges, modelLatency(4, 1'b0)); end
        checks++; if (bus.out_data !== 16'h4123) begin errors++; $display("[TB] FAIL data_1234_r4 got=%h want=4123", bus.out_data); end
        handshake();
    endtask

    task automatic test_directed();
        logic [N-1:0] tData [4] = '{16'h1234, 16'h8001, 16'hBEEF, 16'hBEEF};
        logic [C-1:0] tCnt  [4] = '{4'd4,     4'd15,    4'd0,     4'd0};
        logic         tDir  [4] = '{1'b1,     1'b0,     1'b0,     1'b1};
        logic [N-1:0] tExp  [4] = '{16'h2341, 16'h0003, 16'hBEEF, 16'hBEEF};
        int edges;
        for (int t = 0; t < 4; t++) begin
            sendRequest(tData[t], tCnt[t], tDir[t]);
            waitResult(edges);
            checks++; if (edges != modelLatency(int'(tCnt[t]), tDir[t])) begin errors++; $display("[TB] FAIL directed_latency[%0d] got=%0d want=%0d", t, edges, modelLatency(int'(tCnt[t]), tDir[t])); end
            checks++; if (bus.out_data !== tExp[t]) begin errors++; $display("[TB] FAIL directed_data[%0d] got=%h want=%h", t, bus.out_data, tExp[t]); end
            handshake();
        end
    endtask

    task automatic test_hold_and_ignore();
        int edges;
        logic [N-1:0] held;
        held = modelRot(16'hA5C3, 3, 1'b1);
        sendRequest(16'hA5C3, 4'd3, DIR_LEFT);
        waitResult(edges);
        checks++; if (bus.out_data !== held) begin errors++; $display("[TB] FAIL hold_initial_data got=%h want=%h", bus.out_data, held); end
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h1111;
        bus.in_cnt   = 4'd1;
        bus.in_dir   = DIR_RIGHT;
        for (int c = 0; c < 3; c++) begin
            stepCycle();
            checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== held || bus.in_ready !== 1'b0) begin
                errors++; $display("[TB] FAIL hold_cycle[%0d] valid=%b data=%h in_ready=%b want 1/%h/0", c, bus.out_valid, bus.out_data, bus.in_ready, held);
            end
        end
        handshake();
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("[TB] FAIL handoff_no_accept valid=%b in_ready=%b busy=%b want 0/1/0", bus.out_valid, bus.in_ready, busy);
        end
        checks++; if (bus.out_data !== held) begin errors++; $display("[TB] FAIL idle_keeps_data got=%h want=%h", bus.out_data, held); end
        stepCycle();
        bus.in_valid = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL accept_after_handoff busy=%b want=1", busy); end
        waitResult(edges);
        checks++; if (bus.out_data !== 16'h8888) begin errors++; $display("[TB] FAIL late_request_data got=%h want=8888", bus.out_data); end
        handshake();
    endtask

    task automatic test_midrun_reset();
        int edges;
        logic seen;
        sendRequest(16'h1234, 4'd15, DIR_RIGHT);
        stepCycle();
        stepCycle();
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL midrun_reset valid=%b busy=%b in_ready=%b want 0/0/1", bus.out_valid, busy, bus.in_ready);
        end
        checks++; if (bus.out_data !== 16'h0000) begin errors++; $display("[TB] FAIL midrun_reset_data got=%h want=0000", bus.out_data); end
        stepCycle();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            stepCycle();
            if (bus.out_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("[TB] FAIL aborted_result_emitted got=1 want=0"); end
        sendRequest(16'h00FF, 4'd8, DIR_RIGHT);
        waitResult(edges);
        checks++; if (edges != modelLatency(8, 1'b0)) begin errors++; $display("[TB] FAIL post_reset_latency got=%0d want=%0d", edges, modelLatency(8, 1'b0)); end
        checks++; if (bus.out_data !== 16'hFF00) begin errors++; $display("[TB] FAIL post_reset_data got=%h want=FF00", bus.out_data); end
        handshake();
    endtask

    task automatic test_back_to_back();
        int edges;
        int k;
        bit left;
        int hold;
        logic [N-1:0] d;
        logic [N-1:0] expData;
        for (int t = 0; t < 30; t++) begin
            d       = N'($urandom);
            k       = $urandom_range(0, N - 1);
            left    = 1'($urandom_range(0, 1));
            hold    = $urandom_range(0, 3);
            expData = modelRot(d, k, left);
            sendRequest(d, C'(k), left);
            waitResult(edges);
            checks++; if (edges != modelLatency(k, left)) begin errors++; $display("[TB] FAIL rand_latency[%0d] got=%0d want=%0d", t, edges, modelLatency(k, left)); end
            checks++; if (bus.out_data !== expData) begin errors++; $display("[TB] FAIL rand_data[%0d] d=%h k=%0d left=%0d got=%h want=%h", t, d, k, left, bus.out_data, expData); end
            for (int c = 0; c < hold; c++) stepCycle();
            checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== expData) begin
                errors++; $display("[TB] FAIL rand_hold[%0d] valid=%b data=%h want 1/%h", t, bus.out_valid, bus.out_data, expData);
            end
            handshake();
            checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
                errors++; $display("[TB] FAIL rand_release[%0d] valid=%b in_ready=%b want 0/1", t, bus.out_valid, bus.in_ready);
            end
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_cnt    = '0;
        bus.in_dir    = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_directed();
        test_hold_and_ignore();
        test_midrun_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
